// File: rtl/can_crc_pkg.sv
// Shared CAN CRC polynomials and the engine state encoding.
package can_crc_pkg;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam logic [16:0] CAN_CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CAN_CRC21_POLY = 21'h102899;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_TX_OUT,
    ST_RX_CMP,
    ST_DONE
  } crc_state_t;

endpackage

// File: rtl/can_crc_step.sv
// One bit of the CRC LFSR, MSB-first; purely combinational.
module can_crc_step #(
  parameter int               CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = '0
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic             data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  assign fb    = data_i ^ crc_i[CRC_W-1];
  assign crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/can_crc_engine.sv
// Bit-serial CAN CRC: accumulates the protected field, then serialises the CRC (TX)
// or folds the received CRC in and checks for a zero residue (RX).
module can_crc_engine
  import can_crc_pkg::*;
#(
  parameter int               CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = CAN_CRC15_POLY,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_tx,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             seq_done,
  input  logic             bit_ready,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_bit_out,
  output logic             crc_bit_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err
);

  localparam int CNT_W = $clog2(CRC_W);

  if (CRC_W < 3 || CRC_W > 32) begin : g_bad_width
    $error("can_crc_engine: CRC_W must be within 3..32");
  end

  crc_state_t       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_tx_q;
  logic             done_q;
  logic             ok_q;
  logic             err_q;

  can_crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_i  (crc_q),
    .data_i (data_in),
    .crc_o  (crc_d)
  );

  // abort outranks start, which outranks whatever the current state would do
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= '0;
      cnt_q     <= '0;
      mode_tx_q <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
      end else if (start) begin
        state_q   <= ST_CALC;
        crc_q     <= INIT;
        mode_tx_q <= mode_tx;
        ok_q      <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_CALC: begin
            if (data_valid) crc_q <= crc_d;
            if (seq_done) begin
              cnt_q   <= CNT_W'(CRC_W - 1);
              state_q <= mode_tx_q ? ST_TX_OUT : ST_RX_CMP;
            end
          end
          ST_TX_OUT: begin
            if (bit_ready) begin
              if (cnt_q == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          ST_RX_CMP: begin
            if (data_valid) begin
              crc_q <= crc_d;
              if (cnt_q == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                ok_q    <= (crc_d == '0);
                err_q   <= (crc_d != '0);
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign crc_value     = crc_q;
  assign crc_bit_valid = (state_q == ST_TX_OUT);
  assign crc_bit_out   = (state_q == ST_TX_OUT) & crc_q[cnt_q];
  assign busy          = (state_q == ST_CALC) || (state_q == ST_TX_OUT) || (state_q == ST_RX_CMP);
  assign done          = done_q;
  assign crc_ok        = ok_q;
  assign crc_err       = err_q;

endmodule

// File: tb/tb_can_crc_engine.sv
// Directed bench for can_crc_engine: CRC-15 vector table plus RX, abort, reset and CRC-17 sequences.
module tb_can_crc_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, mode_tx = 1'b0, data_valid = 1'b0;
  logic data_in = 1'b0, seq_done = 1'b0, bit_ready = 1'b0;

  logic [14:0] crc_value;
  logic        crc_bit_out, crc_bit_valid, busy, done, crc_ok, crc_err;
  logic [16:0] crc17_value;
  logic        b17_out, b17_vld, busy17, done17, ok17, err17;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  can_crc_engine u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_tx(mode_tx),
    .data_valid(data_valid), .data_in(data_in), .seq_done(seq_done), .bit_ready(bit_ready),
    .crc_value(crc_value), .crc_bit_out(crc_bit_out), .crc_bit_valid(crc_bit_valid),
    .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err)
  );

  can_crc_engine #(.CRC_W(17), .POLY(17'h1685B), .INIT(17'h10000)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_tx(mode_tx),
    .data_valid(data_valid), .data_in(data_in), .seq_done(seq_done), .bit_ready(bit_ready),
    .crc_value(crc17_value), .crc_bit_out(b17_out), .crc_bit_valid(b17_vld),
    .busy(busy17), .done(done17), .crc_ok(ok17), .crc_err(err17)
  );

  typedef struct {
    logic        st, md, dv, di, sd, br, ab;
    logic [14:0] crc;
    logic        bsy, bv, bo, dn, ok, er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic md, logic dv, logic di, logic sd, logic br, logic ab,
                              logic [14:0] crc, logic bsy, logic bv, logic bo, logic dn);
    vec_t v;
    v.st = st; v.md = md; v.dv = dv; v.di = di; v.sd = sd; v.br = br; v.ab = ab;
    v.crc = crc; v.bsy = bsy; v.bv = bv; v.bo = bo; v.dn = dn; v.ok = 1'b0; v.er = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic md, input logic dv, input logic di,
                       input logic sd, input logic br, input logic ab);
    start = st; mode_tx = md; data_valid = dv; data_in = di;
    seq_done = sd; bit_ready = br; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string nm, input logic [14:0] crc, input logic bsy, input logic bv,
                          input logic bo, input logic dn, input logic ok, input logic er);
    chk({nm, " crc"}, 32'(crc_value), 32'(crc));
    chk({nm, " busy"}, 32'(busy), 32'(bsy));
    chk({nm, " bit_valid"}, 32'(crc_bit_valid), 32'(bv));
    chk({nm, " bit_out"}, 32'(crc_bit_out), 32'(bo));
    chk({nm, " done"}, 32'(done), 32'(dn));
    chk({nm, " ok"}, 32'(crc_ok), 32'(ok));
    chk({nm, " err"}, 32'(crc_err), 32'(er));
  endtask

  // CRC-15 of the single bit '1' is 0x4599, transmitted MSB first
  logic [14:0] tx_seq;
  logic [14:0] rx_crc;

  initial begin
    tx_seq = 15'b100010110011001;

    // Accumulate 1,0 then seq_done in RX, then abort
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 15'h0000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 15'h4599, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 15'h4EAB, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 15'h4EAB, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 15'h4EAB, 0, 0, 0, 0));
    // TX: bit 1 together with seq_done, then 15 bit_ready strobes
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 15'h0000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 15'h4599, 1, 1, tx_seq[14], 0));
    for (int k = 1; k <= 15; k++) begin
      if (k < 15)
        vecs.push_back(mk(0, 0, k == 3, 1, k == 4, 1, 0, 15'h4599, 1, 1, tx_seq[14-k], 0));
      else
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 15'h4599, 0, 0, 0, 1));
    end
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 15'h4599, 0, 0, 0, 0));

    #12;
    chk_outs("reset", 15'h0, 0, 0, 0, 0, 0, 0);
    chk("reset crc17", 32'(crc17_value), 32'h0);
    chk("reset any17", 32'({b17_out, b17_vld, busy17, done17, ok17, err17}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].md, vecs[i].dv, vecs[i].di, vecs[i].sd, vecs[i].br, vecs[i].ab);
      chk_outs($sformatf("vec%0d", i), vecs[i].crc, vecs[i].bsy, vecs[i].bv, vecs[i].bo,
               vecs[i].dn, vecs[i].ok, vecs[i].er);
    end

    // RX residue check: pass 0 feeds the correct CRC, pass 1 flips the 8th CRC bit
    for (int pass = 0; pass < 2; pass++) begin
      rx_crc = 15'h4599;
      if (pass == 1) rx_crc[7] = ~rx_crc[7];
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      for (int b = 14; b >= 1; b--) drive(0, 0, 1, rx_crc[b], 0, 1, 0);
      chk($sformatf("rx%0d busy before last", pass), 32'(busy), 32'h1);
      chk($sformatf("rx%0d done before last", pass), 32'(done), 32'h0);
      drive(0, 0, 1, rx_crc[0], 0, 0, 0);
      chk($sformatf("rx%0d done", pass), 32'(done), 32'h1);
      chk($sformatf("rx%0d busy", pass), 32'(busy), 32'h0);
      chk($sformatf("rx%0d ok", pass), 32'(crc_ok), 32'(pass == 0));
      chk($sformatf("rx%0d err", pass), 32'(crc_err), 32'(pass == 1));
      if (pass == 0) chk("rx0 residue", 32'(crc_value), 32'h0);
      drive(0, 0, 1, 1, 0, 0, 0);
      chk($sformatf("rx%0d done one pulse", pass), 32'(done), 32'h0);
      chk($sformatf("rx%0d flags held", pass), 32'({crc_ok, crc_err}), (pass == 0) ? 32'h2 : 32'h1);
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("restart clears flags", 32'({crc_ok, crc_err}), 32'h0);

    // Abort in TX_OUT after five strobes
    drive(0, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 1, 0);
    chk_outs("tx after 5", 15'h4599, 1, 1, tx_seq[9], 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_outs("abort", 15'h4599, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("abort no done", 32'(done), 32'h0);

    // Start while busy restarts from INIT
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk_outs("restart busy", 15'h0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    chk("restart crc", 32'(crc_value), 32'h4599);

    // Asynchronous reset mid-frame
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async reset", 15'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // CRC-17 instance with the CAN FD start value
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("crc17 init", 32'(crc17_value), 32'h10000);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("crc17 bit0", 32'(crc17_value), 32'h1685B);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
